// File: rtl/pid_seq.sv
// Sample sequencer between the inertial sensor and the PID block: feeds samples,
// times the integrate strobe, captures/scales the motor command, and runs the power FSM.
module pid_seq #(
    parameter logic        fast_sim = 1'b1,
    parameter logic [15:0] VLD_TMO  = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic        rider_off,
    input  logic        vld,
    input  logic [15:0] ptch,
    input  logic [15:0] ptch_rt,
    input  logic [11:0] PID_cntrl,
    input  logic [7:0]  ss_tmr,
    output logic [15:0] ptch_q,
    output logic [15:0] ptch_rt_q,
    output logic        pid_vld,
    output logic        pid_rider_off,
    output logic [11:0] mtr_cmd,
    output logic        mtr_en,
    output logic [1:0]  state,
    output logic        ovr
);

    localparam int unsigned PW = 16;
    localparam int unsigned CW = 12;
    localparam int unsigned WW = 16;
    localparam logic [WW-1:0] WD_LIM = fast_sim ? 16'd1000 : VLD_TMO;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_SOFT  = 2'b01,
        ST_RUN   = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_VLD  = 2'b01,
        SEQ_CAP  = 2'b10
    } seq_e;

    state_e        state_q, state_d;
    seq_e          seq_q, seq_d;
    logic [PW-1:0] ptch_q_r, ptch_d;
    logic [PW-1:0] rt_q, rt_d;
    logic [PW-1:0] pend_ptch_q, pend_ptch_d;
    logic [PW-1:0] pend_rt_q, pend_rt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pid_vld_q, pid_vld_d;
    logic [CW-1:0] mtr_q, mtr_d;
    logic          mtr_en_q, mtr_en_d;
    logic          ovr_q, ovr_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          wd_exp;
    logic          capture;
    logic signed [20:0] scaled_full;
    logic [CW-1:0] scaled_cmd;

    // Soft-start scaling: signed command times unsigned ramp, divided by 256.
    assign scaled_full = $signed(PID_cntrl) * $signed({1'b0, ss_tmr});
    assign scaled_cmd  = CW'(scaled_full >>> 8);
    assign wd_exp      = (wd_q == WD_LIM);

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        ptch_d      = ptch_q_r;
        rt_d        = rt_q;
        pend_ptch_d = pend_ptch_q;
        pend_rt_d   = pend_rt_q;
        pend_vld_d  = pend_vld_q;
        pid_vld_d   = 1'b0;
        mtr_d       = mtr_q;
        ovr_d       = ovr_q;
        wd_d        = wd_q;
        capture     = 1'b0;

        // Power FSM: rider/power loss beats watchdog beats ramp completion.
        unique case (state_q)
            ST_OFF:   if (pwr_up && !rider_off) state_d = ST_SOFT;
            ST_SOFT,
            ST_RUN: begin
                if (!pwr_up || rider_off)                     state_d = ST_OFF;
                else if (wd_exp)                              state_d = ST_FAULT;
                else if (state_q == ST_SOFT && ss_tmr == 8'hFF) state_d = ST_RUN;
            end
            default:  if (!pwr_up) state_d = ST_OFF;
        endcase

        // Three-cycle sample sequence; a held sample starts as soon as the previous one finishes.
        unique case (seq_q)
            SEQ_IDLE: begin
                if (pend_vld_q) begin
                    ptch_d     = pend_ptch_q;
                    rt_d       = pend_rt_q;
                    pend_vld_d = 1'b0;
                    pid_vld_d  = 1'b1;
                    seq_d      = SEQ_VLD;
                end else if (vld) begin
                    ptch_d    = ptch;
                    rt_d      = ptch_rt;
                    pid_vld_d = 1'b1;
                    seq_d     = SEQ_VLD;
                end
            end
            SEQ_VLD: seq_d = SEQ_CAP;
            SEQ_CAP: begin
                seq_d   = SEQ_IDLE;
                capture = 1'b1;
            end
            default: seq_d = SEQ_IDLE;
        endcase

        if (vld && (seq_q != SEQ_IDLE || pend_vld_q)) begin
            if (!pend_vld_d) begin
                pend_vld_d  = 1'b1;
                pend_ptch_d = ptch;
                pend_rt_d   = ptch_rt;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (state_d == ST_OFF || state_d == ST_FAULT) mtr_d = '0;
        else if (capture && state_q == ST_SOFT)       mtr_d = scaled_cmd;
        else if (capture && state_q == ST_RUN)        mtr_d = PID_cntrl;

        mtr_en_d = (state_d == ST_SOFT) || (state_d == ST_RUN);

        if (vld || state_q == ST_OFF || state_q == ST_FAULT) wd_d = '0;
        else if (!wd_exp)                                    wd_d = wd_q + WW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            seq_q       <= SEQ_IDLE;
            ptch_q_r    <= '0;
            rt_q        <= '0;
            pend_ptch_q <= '0;
            pend_rt_q   <= '0;
            pend_vld_q  <= 1'b0;
            pid_vld_q   <= 1'b0;
            mtr_q       <= '0;
            mtr_en_q    <= 1'b0;
            ovr_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            ptch_q_r    <= ptch_d;
            rt_q        <= rt_d;
            pend_ptch_q <= pend_ptch_d;
            pend_rt_q   <= pend_rt_d;
            pend_vld_q  <= pend_vld_d;
            pid_vld_q   <= pid_vld_d;
            mtr_q       <= mtr_d;
            mtr_en_q    <= mtr_en_d;
            ovr_q       <= ovr_d;
            wd_q        <= wd_d;
        end
    end

    assign ptch_q        = ptch_q_r;
    assign ptch_rt_q     = rt_q;
    assign pid_vld       = pid_vld_q;
    assign mtr_cmd       = mtr_q;
    assign mtr_en        = mtr_en_q;
    assign state         = state_q;
    assign ovr           = ovr_q;
    // Integrator clear follows the live rider_off input as well as the idle states.
    assign pid_rider_off = (state_q == ST_OFF) || (state_q == ST_FAULT) || rider_off;

endmodule
